// File: rtl/board_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  board_ram_arbiter_if : master-side and RAM-side signals of the board RAM
//  arbiter (clear control, game port, VGA port, RAM port).
//  Revision: 1.0
// ============================================================================
interface board_ram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
);
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic [DATA_W-1:0] game_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Arbiter side
  modport slave (
    input  clear_start, game_req, game_we, game_addr, game_wdata,
           vga_req, vga_addr, ram_q,
    output clear_busy, clear_done, game_gnt, game_rvalid, game_rdata,
           vga_gnt, vga_rvalid, vga_rdata, ram_address, ram_data, ram_wren
  );

  // Masters plus RAM side
  modport master (
    output clear_start, game_req, game_we, game_addr, game_wdata,
           vga_req, vga_addr, ram_q,
    input  clear_busy, clear_done, game_gnt, game_rvalid, game_rdata,
           vga_gnt, vga_rvalid, vga_rdata, ram_address, ram_data, ram_wren
  );
endinterface
`default_nettype wire

// File: rtl/board_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  board_ram_arbiter : shares the single-port board RAM between the clear
//  engine, the game engine and the VGA scanout reader.
//  Revision: 1.0
// ============================================================================
module board_ram_arbiter #(
  parameter int                ADDR_W     = 15,
  parameter int                DATA_W     = 3,
  parameter int                BOARD_W    = 160,
  parameter int                BOARD_H    = 120,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter int                STARVE_MAX = 15
) (
  input  wire logic            CLOCK_50,
  input  wire logic            resetn,
  board_ram_arbiter_if.slave   bus
);

  localparam int Y_W  = 7;
  localparam int X_W  = ADDR_W - Y_W;
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  localparam logic [X_W-1:0]  c_X_LAST     = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0]  c_Y_LAST     = Y_W'(BOARD_H - 1);
  localparam logic [SC_W-1:0] c_STARVE_MAX = SC_W'(STARVE_MAX);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [SC_W-1:0]   r_starve;
  logic              r_clear_done;
  logic              r_game_tag;
  logic              r_vga_tag;
  logic [DATA_W-1:0] r_game_rdata;
  logic [DATA_W-1:0] r_vga_rdata;
  logic [ADDR_W-1:0] r_addr_last;
  logic [DATA_W-1:0] r_data_last;

  logic              w_run;
  logic              w_vga_starved;
  logic              w_game_gnt;
  logic              w_vga_gnt;
  logic              w_sweep_last;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data;
  logic              w_ram_wren;

  // A starved VGA request pre-empts the game; otherwise the game has priority.
  always_comb begin
    w_run         = (r_state == S_RUN);
    w_vga_starved = (r_starve == c_STARVE_MAX);
    w_game_gnt    = w_run && bus.game_req && !(bus.vga_req && w_vga_starved);
    w_vga_gnt     = w_run && bus.vga_req && (w_vga_starved || !bus.game_req);
    w_sweep_last  = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
  end

  always_comb begin
    w_ram_addr = r_addr_last;
    w_ram_data = r_data_last;
    w_ram_wren = 1'b0;
    if (!w_run) begin
      w_ram_addr = {r_x, r_y};
      w_ram_data = CLEAR_VAL;
      w_ram_wren = 1'b1;
    end else if (w_game_gnt) begin
      w_ram_addr = bus.game_addr;
      w_ram_data = bus.game_wdata;
      w_ram_wren = bus.game_we;
    end else if (w_vga_gnt) begin
      w_ram_addr = bus.vga_addr;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_CLEAR;
      r_x          <= '0;
      r_y          <= '0;
      r_starve     <= '0;
      r_clear_done <= 1'b0;
      r_game_tag   <= 1'b0;
      r_vga_tag    <= 1'b0;
      r_game_rdata <= '0;
      r_vga_rdata  <= '0;
      r_addr_last  <= '0;
      r_data_last  <= '0;
    end else begin
      r_addr_last  <= w_ram_addr;
      r_data_last  <= w_ram_data;
      r_game_tag   <= w_game_gnt && !bus.game_we;
      r_vga_tag    <= w_vga_gnt;
      r_clear_done <= 1'b0;
      if (r_game_tag) begin
        r_game_rdata <= bus.ram_q;
      end
      if (r_vga_tag) begin
        r_vga_rdata <= bus.ram_q;
      end
      case (r_state)
        S_CLEAR: begin
          r_starve <= '0;
          if (bus.clear_start) begin
            r_x <= '0;
            r_y <= '0;
          end else if (w_sweep_last) begin
            r_x          <= '0;
            r_y          <= '0;
            r_state      <= S_RUN;
            r_clear_done <= 1'b1;
          end else if (r_y == c_Y_LAST) begin
            r_y <= '0;
            r_x <= r_x + 1'b1;
          end else begin
            r_y <= r_y + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.vga_req && !w_vga_gnt) begin
            if (!w_vga_starved) begin
              r_starve <= r_starve + 1'b1;
            end
          end else begin
            r_starve <= '0;
          end
          if (bus.clear_start) begin
            r_state <= S_CLEAR;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Read data is passed straight through in the return cycle, then held.
  assign bus.game_rvalid = r_game_tag;
  assign bus.game_rdata  = r_game_tag ? bus.ram_q : r_game_rdata;
  assign bus.vga_rvalid  = r_vga_tag;
  assign bus.vga_rdata   = r_vga_tag ? bus.ram_q : r_vga_rdata;
  assign bus.game_gnt    = w_game_gnt;
  assign bus.vga_gnt     = w_vga_gnt;
  assign bus.clear_busy  = (r_state == S_CLEAR);
  assign bus.clear_done  = r_clear_done;
  assign bus.ram_address = w_ram_addr;
  assign bus.ram_data    = w_ram_data;
  assign bus.ram_wren    = w_ram_wren;

endmodule
`default_nettype wire

// File: tb/tb_board_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_board_ram_arbiter : self-checking bench with a behavioural RAM and a
//  board-content model; randomized game/VGA traffic.
//  Revision: 1.0
// ============================================================================
module tb_board_ram_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 3;
  localparam int BW     = 160;
  localparam int BH     = 120;
  localparam int SMAX   = 15;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  logic [DATA_W-1:0] ram       [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q_r;
  logic [DATA_W-1:0] hold_game;
  logic [DATA_W-1:0] hold_vga;

  always #5 CLOCK_50 = ~CLOCK_50;

  board_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  board_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOARD_W(BW), .BOARD_H(BH),
    .CLEAR_VAL(3'b000), .STARVE_MAX(SMAX)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .bus     (bus)
  );

  // Single-port synchronous RAM: q shows the old contents one cycle later.
  always @(posedge CLOCK_50) begin
    if (bus.ram_wren) ram[bus.ram_address] <= bus.ram_data;
    ram_q_r <= ram[bus.ram_address];
  end
  assign bus.ram_q = ram_q_r;

  function automatic logic [ADDR_W-1:0] mk_addr(input int x, input int y);
    logic [7:0] xs;
    logic [6:0] ys;
    xs = x[7:0];
    ys = y[6:0];
    return {xs, ys};
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0)
      return mk_addr(int'($urandom_range(0, BW-1)), int'($urandom_range(0, BH-1)));
    return mk_addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endfunction

  task automatic model_clear();
    for (int x = 0; x < BW; x++)
      for (int y = 0; y < BH; y++)
        model_mem[mk_addr(x, y)] = 3'b000;
  endtask

  task automatic idle_inputs();
    bus.clear_start = 1'b0;
    bus.game_req    = 1'b0;
    bus.game_we     = 1'b0;
    bus.game_addr   = '0;
    bus.game_wdata  = '0;
    bus.vga_req     = 1'b0;
    bus.vga_addr    = '0;
  endtask

  // Entered at the sample point showing sweep position 0.
  task automatic run_sweep(input string tag);
    logic [ADDR_W-1:0] exp_a;
    int bad = 0;
    for (int i = 0; i < BW*BH; i++) begin
      exp_a = mk_addr(i / BH, i % BH);
      if (bad == 0 && (bus.ram_wren !== 1'b1 || bus.ram_address !== exp_a ||
          bus.ram_data !== 3'b000 || bus.clear_busy !== 1'b1 || bus.clear_done !== 1'b0 ||
          bus.game_gnt !== 1'b0 || bus.vga_gnt !== 1'b0)) begin
        errors++;
        bad = 1;
        $display("FAIL %s_sweep pos %0d: addr=%h wren=%b data=%b busy=%b done=%b; required addr=%h wren=1 data=0 busy=1 done=0",
                 tag, i, bus.ram_address, bus.ram_wren, bus.ram_data, bus.clear_busy, bus.clear_done, exp_a);
      end
      @(negedge CLOCK_50); #1;
    end
    checks++;
    checks++;
    if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b want 0", tag, bus.clear_busy); end
    checks++;
    if (bus.clear_done !== 1'b1) begin errors++; $display("FAIL %s_done_pulse: got %b want 1", tag, bus.clear_done); end
    checks++;
    if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL %s_idle_wren: got %b want 0", tag, bus.ram_wren); end
    @(negedge CLOCK_50); #1;
    checks++;
    if (bus.clear_done !== 1'b0) begin errors++; $display("FAIL %s_done_once: got %b want 0", tag, bus.clear_done); end
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50); #1;
    checks++;
    if (bus.clear_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", bus.clear_busy); end
    checks++;
    if (bus.clear_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.clear_done); end
    checks++;
    if ({bus.game_rvalid, bus.vga_rvalid, bus.game_gnt, bus.vga_gnt} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b want 0000", {bus.game_rvalid, bus.vga_rvalid, bus.game_gnt, bus.vga_gnt});
    end
    checks++;
    if ({bus.game_rdata, bus.vga_rdata} !== 6'b0) begin
      errors++; $display("FAIL rst_rdata: got %b/%b want 000/000", bus.game_rdata, bus.vga_rdata);
    end
    checks++;
    if (bus.ram_address !== '0 || bus.ram_wren !== 1'b1) begin
      errors++; $display("FAIL rst_ram: addr=%h wren=%b want 0000/1", bus.ram_address, bus.ram_wren);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    #1;
    run_sweep("boot");
  endtask

  task automatic test_game_rw();
    @(negedge CLOCK_50);
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = mk_addr(5, 7); bus.game_wdata = 3'b001;
    #1;
    checks++;
    if (bus.game_gnt !== 1'b1 || bus.ram_wren !== 1'b1 || bus.ram_address !== mk_addr(5, 7) || bus.ram_data !== 3'b001) begin
      errors++; $display("FAIL game_write: gnt=%b wren=%b addr=%h data=%b want 1/1/%h/001",
                         bus.game_gnt, bus.ram_wren, bus.ram_address, bus.ram_data, mk_addr(5, 7));
    end
    model_mem[mk_addr(5, 7)] = 3'b001;
    @(negedge CLOCK_50);
    bus.game_we = 1'b0;
    #1;
    checks++;
    if (bus.game_gnt !== 1'b1 || bus.ram_wren !== 1'b0) begin
      errors++; $display("FAIL game_read_gnt: gnt=%b wren=%b want 1/0", bus.game_gnt, bus.ram_wren);
    end
    @(negedge CLOCK_50);
    bus.game_req = 1'b0;
    #1;
    checks++;
    if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 3'b001 || bus.vga_rvalid !== 1'b0) begin
      errors++; $display("FAIL game_raw: rvalid=%b rdata=%b vga_rvalid=%b want 1/001/0",
                         bus.game_rvalid, bus.game_rdata, bus.vga_rvalid);
    end
    @(negedge CLOCK_50); #1;
    checks++;
    if (bus.game_rvalid !== 1'b0 || bus.game_rdata !== 3'b001) begin
      errors++; $display("FAIL game_hold: rvalid=%b rdata=%b want 0/001", bus.game_rvalid, bus.game_rdata);
    end
    hold_game = 3'b001;
  endtask

  task automatic test_vga_read();
    @(negedge CLOCK_50);
    bus.vga_req = 1'b1; bus.vga_addr = mk_addr(159, 119);
    #1;
    checks++;
    if (bus.vga_gnt !== 1'b1 || bus.game_gnt !== 1'b0 || bus.ram_wren !== 1'b0 || bus.ram_address !== mk_addr(159, 119)) begin
      errors++; $display("FAIL vga_gnt: gnt=%b/%b wren=%b addr=%h want vga only, no write",
                         bus.vga_gnt, bus.game_gnt, bus.ram_wren, bus.ram_address);
    end
    @(negedge CLOCK_50);
    bus.vga_req = 1'b0;
    #1;
    checks++;
    if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== model_mem[mk_addr(159, 119)] || bus.game_rvalid !== 1'b0) begin
      errors++; $display("FAIL vga_read: rvalid=%b rdata=%b game_rvalid=%b want 1/000/0",
                         bus.vga_rvalid, bus.vga_rdata, bus.game_rvalid);
    end
    hold_vga = 3'b000;
  endtask

  task automatic test_contention();
    logic exp_v;
    @(negedge CLOCK_50);
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = mk_addr(10, 20);
    bus.vga_req  = 1'b1; bus.vga_addr = mk_addr(100, 50);
    for (int k = 0; k < 48; k++) begin
      #1;
      exp_v = (k % 16 == 15);
      checks++;
      if (bus.vga_gnt !== exp_v || bus.game_gnt !== !exp_v) begin
        errors++; $display("FAIL contend_gnt k=%0d: game=%b vga=%b want game=%b vga=%b",
                           k, bus.game_gnt, bus.vga_gnt, !exp_v, exp_v);
      end
      checks++;
      if (k > 0 && (bus.vga_rvalid !== ((k-1) % 16 == 15) || bus.game_rvalid !== ((k-1) % 16 != 15))) begin
        errors++; $display("FAIL contend_rvalid k=%0d: game=%b vga=%b", k, bus.game_rvalid, bus.vga_rvalid);
      end
      @(negedge CLOCK_50);
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.vga_rvalid !== 1'b1 || bus.game_rvalid !== 1'b0 || bus.vga_rdata !== 3'b000) begin
      errors++; $display("FAIL contend_tail: vga_rvalid=%b game_rvalid=%b vga_rdata=%b want 1/0/000",
                         bus.vga_rvalid, bus.game_rvalid, bus.vga_rdata);
    end
    hold_game = model_mem[mk_addr(10, 20)];
    hold_vga  = model_mem[mk_addr(100, 50)];
  endtask

  task automatic test_random();
    logic g_act = 1'b0, g_we = 1'b0, v_act = 1'b0;
    logic [ADDR_W-1:0] g_addr = '0, v_addr = '0;
    logic [DATA_W-1:0] g_wd = '0, pg_d = '0, pv_d = '0;
    logic pg = 1'b0, pv = 1'b0, eg, ev;
    int v_wait = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge CLOCK_50);
      if (!g_act && c < 400 && $urandom_range(0, 1) == 1) begin
        g_act = 1'b1; g_we = 1'($urandom_range(0, 1)); g_addr = rnd_addr(); g_wd = 3'($urandom_range(0, 7));
      end
      if (!v_act && c < 400 && $urandom_range(0, 2) != 0) begin
        v_act = 1'b1; v_addr = rnd_addr();
      end
      bus.game_req = g_act; bus.game_we = g_we; bus.game_addr = g_addr; bus.game_wdata = g_wd;
      bus.vga_req  = v_act; bus.vga_addr = v_addr;
      #1;
      // VGA waiting 15 cycles beats the game; else game first, then VGA.
      ev = v_act && (v_wait >= SMAX || !g_act);
      eg = g_act && !ev;
      checks++;
      if (bus.game_gnt !== eg || bus.vga_gnt !== ev) begin
        errors++; $display("FAIL rnd_gnt c=%0d: game=%b vga=%b want %b/%b", c, bus.game_gnt, bus.vga_gnt, eg, ev);
      end
      checks++;
      if (bus.game_rvalid !== pg || bus.game_rdata !== (pg ? pg_d : hold_game)) begin
        errors++; $display("FAIL rnd_game_rd c=%0d: rvalid=%b rdata=%b want %b/%b",
                           c, bus.game_rvalid, bus.game_rdata, pg, pg ? pg_d : hold_game);
      end
      checks++;
      if (bus.vga_rvalid !== pv || bus.vga_rdata !== (pv ? pv_d : hold_vga)) begin
        errors++; $display("FAIL rnd_vga_rd c=%0d: rvalid=%b rdata=%b want %b/%b",
                           c, bus.vga_rvalid, bus.vga_rdata, pv, pv ? pv_d : hold_vga);
      end
      checks++;
      if (eg ? (bus.ram_address !== g_addr || bus.ram_wren !== g_we || (g_we && bus.ram_data !== g_wd))
             : (bus.ram_wren !== 1'b0 || (ev && bus.ram_address !== v_addr))) begin
        errors++; $display("FAIL rnd_ram c=%0d: addr=%h wren=%b data=%b", c, bus.ram_address, bus.ram_wren, bus.ram_data);
      end
      if (pg) hold_game = pg_d;
      if (pv) hold_vga  = pv_d;
      if (eg && g_we) model_mem[g_addr] = g_wd;
      pg = eg && !g_we;
      if (pg) pg_d = model_mem[g_addr];
      pv = ev;
      if (pv) pv_d = model_mem[v_addr];
      v_wait = (v_act && !ev) ? v_wait + 1 : 0;
      if (eg) g_act = 1'b0;
      if (ev) v_act = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_clear_restart();
    logic [DATA_W-1:0] exp_d;
    @(negedge CLOCK_50);
    bus.clear_start = 1'b1;
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = mk_addr(5, 7);
    exp_d = model_mem[mk_addr(5, 7)];
    #1;
    checks++;
    if (bus.game_gnt !== 1'b1) begin errors++; $display("FAIL clr_inflight_gnt: got %b want 1", bus.game_gnt); end
    @(negedge CLOCK_50);
    idle_inputs();
    #1;
    checks++;
    if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== exp_d || bus.clear_busy !== 1'b1 || bus.ram_address !== '0) begin
      errors++; $display("FAIL clr_inflight_rd: rvalid=%b rdata=%b busy=%b addr=%h want 1/%b/1/0000",
                         bus.game_rvalid, bus.game_rdata, bus.clear_busy, bus.ram_address, exp_d);
    end
    hold_game = exp_d;
    repeat (1000) begin @(negedge CLOCK_50); #1; end
    checks++;
    if (bus.ram_address !== mk_addr(8, 40) || bus.ram_wren !== 1'b1) begin
      errors++; $display("FAIL clr_pos1000: addr=%h wren=%b want %h/1", bus.ram_address, bus.ram_wren, mk_addr(8, 40));
    end
    bus.clear_start = 1'b1;
    @(negedge CLOCK_50);
    bus.clear_start = 1'b0;
    #1;
    run_sweep("restart");
  endtask

  task automatic test_reset_midread();
    @(negedge CLOCK_50);
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = mk_addr(5, 7);
    #1;
    checks++;
    if (bus.game_gnt !== 1'b1) begin errors++; $display("FAIL rstrd_gnt: got %b want 1", bus.game_gnt); end
    @(posedge CLOCK_50); #1;
    resetn = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.game_rvalid !== 1'b0 || bus.game_rdata !== 3'b000 || bus.vga_rvalid !== 1'b0 || bus.vga_rdata !== 3'b000) begin
      errors++; $display("FAIL rstrd_abort: game %b/%b vga %b/%b want 0/000 0/000",
                         bus.game_rvalid, bus.game_rdata, bus.vga_rvalid, bus.vga_rdata);
    end
    checks++;
    if (bus.clear_busy !== 1'b1 || bus.clear_done !== 1'b0 || bus.ram_address !== '0 || bus.ram_wren !== 1'b1) begin
      errors++; $display("FAIL rstrd_state: busy=%b done=%b addr=%h wren=%b want 1/0/0000/1",
                         bus.clear_busy, bus.clear_done, bus.ram_address, bus.ram_wren);
    end
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    @(negedge CLOCK_50); #1;
    checks++;
    if (bus.game_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_norvalid: got %b want 0", bus.game_rvalid); end
    run_sweep("rstrd");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) begin
      ram[i]       = 3'($urandom_range(1, 7));
      model_mem[i] = 3'b000;
    end
    hold_game = 3'b000;
    hold_vga  = 3'b000;
    test_reset();
    test_game_rw();
    test_vga_read();
    test_contention();
    test_random();
    test_clear_restart();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
